// File: rtl/cache_tag_ctrl.sv
// cache_tag_ctrl: lookup/refill controller that owns the cache tag RAM.
// It drives the RAM address, write enable and write tag, and keeps one valid
// bit per line. It compares the stored tag with each request and raises a line
// refill on a miss. The new tag is written once the refill is acknowledged.
// A flush sweeps every line, clearing both the valid bits and the RAM tags.
//
// Optional feature: define CACHE_PERF_CNT_EN to build saturating hit and miss
// counters. When it is undefined, hit_cnt_o and miss_cnt_o are tied to zero.
module cache_tag_ctrl #(
   parameter int CACHE_TAG_WIDTH = 20,
   parameter int CACHE_INDEX_AW  = 8,
   parameter int OFFSET_W        = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid_i,
   output logic                       req_ready_o,
   input  logic [31:0]                req_addr_i,
   output logic                       resp_valid_o,
   output logic                       resp_hit_o,
   input  logic                       flush_i,
   output logic                       busy_o,
   output logic                       refill_req_o,
   output logic [31:0]                refill_addr_o,
   input  logic                       refill_ack_i,
   output logic [CACHE_INDEX_AW-1:0]  tag_index_o,
   output logic                       tag_wr_en_o,
   output logic [CACHE_TAG_WIDTH-1:0] tag_wr_tag_o,
   input  logic [CACHE_TAG_WIDTH-1:0] tag_rd_tag_i,
   output logic [31:0]                hit_cnt_o,
   output logic [31:0]                miss_cnt_o
);

   localparam int LINES = 1 << CACHE_INDEX_AW;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      MISS,
      WRITE,
      FLUSH
   } state_t;

   state_t                     state;
   state_t                     state_nxt;

   logic [LINES-1:0]           valid_q;
   logic                       flush_pend;
   logic [CACHE_INDEX_AW-1:0]  fcnt;

   // The latched request is held as a tag/index pair. The offset is never needed
   // after the handshake.
   logic [CACHE_TAG_WIDTH-1:0] lat_tag;
   logic [CACHE_INDEX_AW-1:0]  lat_idx;

   logic [CACHE_TAG_WIDTH-1:0] req_tag;
   logic [CACHE_INDEX_AW-1:0]  req_idx;
   logic                       unused_offset;

   logic                       hit;
   logic                       accept;
   logic                       flush_enter;
   logic                       fcnt_last;

   assign req_tag       = req_addr_i[31 -: CACHE_TAG_WIDTH];
   assign req_idx       = req_addr_i[OFFSET_W +: CACHE_INDEX_AW];
   assign unused_offset = ^req_addr_i[OFFSET_W-1:0];

   // The RAM read issued from IDLE lands during LOOKUP. The valid bit gates
   // stale RAM contents, because reset does not clear the RAM itself.
   assign hit         = valid_q[lat_idx] & (tag_rd_tag_i == lat_tag);
   assign fcnt_last   = (fcnt == {CACHE_INDEX_AW{1'b1}});
   assign flush_enter = (state == IDLE) & (flush_i | flush_pend);
   assign busy_o      = (state != IDLE);

   // Saturating increment for the performance counters.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic and all controller outputs.
   always_comb begin
      state_nxt     = state;
      accept        = 1'b0;
      req_ready_o   = 1'b0;
      resp_valid_o  = 1'b0;
      resp_hit_o    = 1'b0;
      refill_req_o  = 1'b0;
      refill_addr_o = '0;
      tag_index_o   = '0;
      tag_wr_en_o   = 1'b0;
      tag_wr_tag_o  = '0;
      case (state)
         IDLE: begin
            // Index is driven straight from the request so the tag arrives in LOOKUP.
            req_ready_o = ~flush_i & ~flush_pend;
            tag_index_o = req_idx;
            if (flush_i | flush_pend) begin
               state_nxt = FLUSH;
            end else if (req_valid_i) begin
               accept    = 1'b1;
               state_nxt = LOOKUP;
            end
         end
         LOOKUP: begin
            tag_index_o = lat_idx;
            if (hit) begin
               resp_valid_o = 1'b1;
               resp_hit_o   = 1'b1;
               state_nxt    = IDLE;
            end else begin
               state_nxt = MISS;
            end
         end
         MISS: begin
            tag_index_o   = lat_idx;
            refill_req_o  = 1'b1;
            refill_addr_o = {lat_tag, lat_idx, {OFFSET_W{1'b0}}};
            if (refill_ack_i) state_nxt = WRITE;
         end
         WRITE: begin
            // The write lands at this edge, so a back-to-back lookup of this line hits.
            tag_index_o  = lat_idx;
            tag_wr_en_o  = 1'b1;
            tag_wr_tag_o = lat_tag;
            resp_valid_o = 1'b1;
            resp_hit_o   = 1'b0;
            state_nxt    = IDLE;
         end
         FLUSH: begin
            tag_index_o  = fcnt;
            tag_wr_en_o  = 1'b1;
            tag_wr_tag_o = '0;
            if (fcnt_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Valid bits, flush sweep counter and deferred-flush flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q    <= '0;
         fcnt       <= '0;
         flush_pend <= 1'b0;
      end else begin
         if (state == WRITE)      valid_q[lat_idx] <= 1'b1;
         else if (state == FLUSH) valid_q[fcnt]    <= 1'b0;

         if (flush_enter)         fcnt <= '0;
         else if (state == FLUSH) fcnt <= fcnt + 1'b1;

         // A flush arriving mid-transaction waits for IDLE. One arriving during
         // the sweep is absorbed by that sweep.
         if ((state == FLUSH) && fcnt_last)
            flush_pend <= 1'b0;
         else if (flush_i && ((state == LOOKUP) || (state == MISS) || (state == WRITE)))
            flush_pend <= 1'b1;
      end
   end

   // Request capture. This is data only, so it has no reset and is used only after a handshake.
   always_ff @(posedge clk) begin
      if (accept) begin
         lat_tag <= req_tag;
         lat_idx <= req_idx;
      end
   end

`ifdef CACHE_PERF_CNT_EN
   logic [31:0] hit_cnt_q;
   logic [31:0] miss_cnt_q;

   // Saturating hit/miss counters, cleared by reset and on entry to a flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (flush_enter) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (resp_valid_o) begin
         if (resp_hit_o) hit_cnt_q  <= sat_inc(hit_cnt_q);
         else            miss_cnt_q <= sat_inc(miss_cnt_q);
      end
   end

   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`else
   assign hit_cnt_o  = '0;
   assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Bench for cache_tag_ctrl. It models the tag RAM as a 1-cycle synchronous-read
// array and predicts hits with a line-level cache model (valid + tag per index).
module tb_cache_tag_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [31:0] req_addr_i;
   logic        resp_valid_o;
   logic        resp_hit_o;
   logic        flush_i;
   logic        busy_o;
   logic        refill_req_o;
   logic [31:0] refill_addr_o;
   logic        refill_ack_i;
   logic [7:0]  tag_index_o;
   logic        tag_wr_en_o;
   logic [19:0] tag_wr_tag_o;
   logic [19:0] tag_rd_tag_i;
   logic [31:0] hit_cnt_o;
   logic [31:0] miss_cnt_o;

   int vectors     = 0;
   int miscompares = 0;

   // Tag RAM environment model.
   logic [19:0] ram [0:255];

   // Reference cache model.
   bit          ref_valid [0:255];
   logic [19:0] ref_tag   [0:255];
   int          ref_hits;
   int          ref_misses;

   cache_tag_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_addr_i   (req_addr_i),
      .resp_valid_o (resp_valid_o),
      .resp_hit_o   (resp_hit_o),
      .flush_i      (flush_i),
      .busy_o       (busy_o),
      .refill_req_o (refill_req_o),
      .refill_addr_o(refill_addr_o),
      .refill_ack_i (refill_ack_i),
      .tag_index_o  (tag_index_o),
      .tag_wr_en_o  (tag_wr_en_o),
      .tag_wr_tag_o (tag_wr_tag_o),
      .tag_rd_tag_i (tag_rd_tag_i),
      .hit_cnt_o    (hit_cnt_o),
      .miss_cnt_o   (miss_cnt_o)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 20'($urandom);
   end

   always @(posedge clk) begin
      if (tag_wr_en_o) ram[tag_index_o] <= tag_wr_tag_o;
      tag_rd_tag_i <= ram[tag_index_o];
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, vectors=%0d", vectors);
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic ref_clear();
      for (int i = 0; i < 256; i++) ref_valid[i] = 1'b0;
      ref_hits   = 0;
      ref_misses = 0;
   endtask

   task automatic chk_cnt();
`ifdef CACHE_PERF_CNT_EN
      chk("hit_cnt", hit_cnt_o, ref_hits);
      chk("miss_cnt", miss_cnt_o, ref_misses);
`else
      chk("hit_cnt_tied", hit_cnt_o, 32'd0);
      chk("miss_cnt_tied", miss_cnt_o, 32'd0);
`endif
   endtask

   // Entered at negedge+1 in the first FLUSH cycle; optionally pulses flush_i mid-sweep.
   task automatic flush_sweep(input int pulse_at);
      int n  = 0;
      bit ok = 1'b1;
      while (busy_o === 1'b1 && n < 400) begin
         if (tag_wr_en_o !== 1'b1 || tag_index_o !== n[7:0] || tag_wr_tag_o !== 20'd0) ok = 1'b0;
         if (n == pulse_at) flush_i = 1'b1;
         n++;
         @(negedge clk);
         flush_i = 1'b0;
         #1;
      end
      chk("flush_cycles", n, 256);
      chk("flush_writes", ok, 1'b1);
      ref_clear();
      chk("post_flush_ready", req_ready_o, 1'b1);
      chk_cnt();
   endtask

   // One request from handshake to return to IDLE; flush or reset may be injected during MISS.
   task automatic do_req(input logic [31:0] addr, input int delay, input bit fl, input bit rs);
      logic [7:0]  idx;
      logic [19:0] tg;
      logic [31:0] line;
      bit          exp_hit;
      bit          fl_eff;
      bit          stable;
      idx     = addr[11:4];
      tg      = addr[31:12];
      line    = {addr[31:4], 4'h0};
      exp_hit = ref_valid[idx] && (ref_tag[idx] == tg);
      fl_eff  = fl && !exp_hit && (delay > 0);

      @(negedge clk);
      req_valid_i = 1'b1;
      req_addr_i  = addr;
      #1;
      chk("req_ready", req_ready_o, 1'b1);
      chk("idle_index", tag_index_o, idx);

      @(negedge clk);
      req_valid_i = 1'b0;
      req_addr_i  = $urandom;
      #1;
      chk("resp_valid_lookup", resp_valid_o, exp_hit);
      chk("resp_hit_lookup", resp_hit_o, exp_hit);
      chk("lookup_no_refill", refill_req_o, 1'b0);
      chk("lookup_busy", busy_o, 1'b1);

      if (exp_hit) begin
         ref_hits++;
      end else begin
         @(negedge clk);
         #1;
         chk("refill_req", refill_req_o, 1'b1);
         chk("refill_addr", refill_addr_o, line);
         chk("miss_no_write", tag_wr_en_o, 1'b0);
         if (rs) begin
            rst = 1'b1;
            #1;
            chk("abort_refill_drop", refill_req_o, 1'b0);
            chk("abort_busy", busy_o, 1'b0);
            chk("abort_no_resp", resp_valid_o, 1'b0);
            @(negedge clk);
            rst = 1'b0;
            ref_clear();
            #1;
            chk_cnt();
            return;
         end
         stable = 1'b1;
         for (int d = 0; d < delay; d++) begin
            if (fl_eff && d == 0) flush_i = 1'b1;
            @(negedge clk);
            flush_i = 1'b0;
            #1;
            if (refill_req_o !== 1'b1 || refill_addr_o !== line || resp_valid_o !== 1'b0) stable = 1'b0;
         end
         chk("refill_hold", stable, 1'b1);
         refill_ack_i = 1'b1;
         @(negedge clk);
         refill_ack_i = 1'b0;
         #1;
         chk("write_en", tag_wr_en_o, 1'b1);
         chk("write_tag", tag_wr_tag_o, tg);
         chk("write_index", tag_index_o, idx);
         chk("miss_resp_valid", resp_valid_o, 1'b1);
         chk("miss_resp_hit", resp_hit_o, 1'b0);
         chk("write_no_refill", refill_req_o, 1'b0);
         ref_valid[idx] = 1'b1;
         ref_tag[idx]   = tg;
         ref_misses++;
      end

      @(negedge clk);
      #1;
      chk("idle_busy", busy_o, 1'b0);
      chk_cnt();
      if (fl_eff) begin
         chk("pend_blocks_ready", req_ready_o, 1'b0);
         @(negedge clk);
         #1;
         flush_sweep(-1);
      end else begin
         chk("idle_ready", req_ready_o, 1'b1);
      end
   endtask

   initial begin
      rst          = 1'b1;
      req_valid_i  = 1'b0;
      req_addr_i   = 32'd0;
      flush_i      = 1'b0;
      refill_ack_i = 1'b0;
      ref_clear();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ready", req_ready_o, 1'b1);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_resp_valid", resp_valid_o, 1'b0);
      chk("rst_resp_hit", resp_hit_o, 1'b0);
      chk("rst_refill_req", refill_req_o, 1'b0);
      chk("rst_refill_addr", refill_addr_o, 32'd0);
      chk("rst_wr_en", tag_wr_en_o, 1'b0);
      chk("rst_wr_tag", tag_wr_tag_o, 20'd0);
      chk("rst_index", tag_index_o, 8'd0);
      chk_cnt();
      @(negedge clk);
      rst = 1'b0;

      // Cold miss, hit, conflict pair.
      do_req(32'h0000_1230, 5, 1'b0, 1'b0);
      do_req(32'h0000_1234, 0, 1'b0, 1'b0);
      do_req(32'h0000_2230, 2, 1'b0, 1'b0);
      do_req(32'h0000_1230, 0, 1'b0, 1'b0);
      do_req(32'h0000_123C, 0, 1'b0, 1'b0);

      // Flush raised during MISS, serviced after the response.
      do_req(32'h0000_2230, 3, 1'b1, 1'b0);
      do_req(32'h0000_1230, 1, 1'b0, 1'b0);

      // Flush and request in the same IDLE cycle.
      @(negedge clk);
      flush_i     = 1'b1;
      req_valid_i = 1'b1;
      req_addr_i  = 32'h0000_1230;
      #1;
      chk("simul_ready", req_ready_o, 1'b0);
      @(negedge clk);
      flush_i     = 1'b0;
      req_valid_i = 1'b0;
      #1;
      chk("simul_flush_busy", busy_o, 1'b1);
      flush_sweep(10);

      // One miss followed by three hits.
      do_req(32'h0000_5670, 1, 1'b0, 1'b0);
      do_req(32'h0000_5674, 0, 1'b0, 1'b0);
      do_req(32'h0000_5678, 0, 1'b0, 1'b0);
      do_req(32'h0000_567C, 0, 1'b0, 1'b0);
`ifdef CACHE_PERF_CNT_EN
      chk("perf_hits3", hit_cnt_o, 32'd3);
      chk("perf_miss1", miss_cnt_o, 32'd1);
`endif

      // Random traffic over a small set of lines to mix hits and conflicts.
      for (int k = 0; k < 40; k++) begin
         logic [31:0] a;
         a = {12'h000, 4'($urandom_range(1, 3)), 4'h2, 4'($urandom_range(0, 3)), 4'($urandom)};
         if ($urandom_range(0, 7) == 0) begin
            @(negedge clk);
            refill_ack_i = 1'b1;
            @(negedge clk);
            refill_ack_i = 1'b0;
            #1;
            chk("stray_ack_idle", busy_o, 1'b0);
         end
         do_req(a, $urandom_range(0, 4), ($urandom_range(0, 11) == 0), 1'b0);
      end

      // Reset while refilling: the aborted request gets no response, and the lines it cleared miss afterwards.
      do_req(32'h0000_7770, 1, 1'b0, 1'b0);
      do_req(32'h0000_7774, 0, 1'b0, 1'b0);
      do_req(32'hABCD_E400, 2, 1'b0, 1'b1);
      do_req(32'h0000_7770, 1, 1'b0, 1'b0);
      do_req(32'h0000_7778, 0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cache_tag_ctrl.md
# cache_tag_ctrl

Lookup/refill controller that owns the cache tag RAM. It drives the RAM's index, write-enable and write-tag, and reads its tag back. It keeps one valid bit per line, compares the stored tag against each incoming request address, and raises a refill request on a miss. After the refill it writes the new tag. It sits between the cache front end and the `tag` storage instance, one per cache.

## Interface
- `CACHE_TAG_WIDTH`, 20, tag bits, equal to `req_addr_i[31:12]`.
- `CACHE_INDEX_AW`, 8, index bits, equal to `req_addr_i[11:4]`; 256 lines.
- `OFFSET_W`, 4, line offset bits. `CACHE_TAG_WIDTH + CACHE_INDEX_AW + OFFSET_W` must equal 32.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid_i` in 1: lookup request valid.
- `req_ready_o` out 1: controller accepts a request this cycle.
- `req_addr_i` in 32: request byte address.
- `resp_valid_o` out 1: one-cycle response pulse.
- `resp_hit_o` out 1: 1 = hit, 0 = miss that has been serviced. Valid only with `resp_valid_o`.
- `flush_i` in 1: invalidate-all request, one-cycle pulse.
- `busy_o` out 1: state ≠ IDLE.
- `refill_req_o` out 1: line refill request to the memory side.
- `refill_addr_o` out 32: line-aligned refill address, with the offset bits forced to 0.
- `refill_ack_i` in 1: refill complete.
- `tag_index_o` out `CACHE_INDEX_AW`: tag RAM address.
- `tag_wr_en_o` out 1: tag RAM write enable.
- `tag_wr_tag_o` out `CACHE_TAG_WIDTH`: tag RAM write data.
- `tag_rd_tag_i` in `CACHE_TAG_WIDTH`: tag RAM read data. The RAM is synchronous-read with 1-cycle latency.
- `hit_cnt_o`, `miss_cnt_o` out 32: performance counters (see Configuration).

## Operation
- **States:** IDLE, LOOKUP, MISS, WRITE, FLUSH.
- **Registers:** `valid[2^CACHE_INDEX_AW]`, the latched request address, `flush_pend`, and the flush counter `fcnt` (`CACHE_INDEX_AW` bits).
- **IDLE**
  - `req_ready_o = ~flush_i & ~flush_pend`.
  - `tag_index_o = req_addr_i[11:4]`, driven combinationally so the read data arrives in LOOKUP.
  - On handshake: latch the address and go to LOOKUP.
  - If `flush_i | flush_pend`: go to FLUSH with `fcnt = 0`. Flush has priority over a same-cycle request.
- **LOOKUP**
  - `tag_index_o` = latched index.
  - Hit is defined as `valid[idx] & (tag_rd_tag_i == latched tag)`.
  - On hit: assert `resp_valid_o=1` and `resp_hit_o=1`, then go to IDLE.
  - On miss: go to MISS.
- **MISS**
  - `refill_req_o=1` and `refill_addr_o = {tag, idx, 4'b0}`, held stable until `refill_ack_i` is sampled high. Then go to WRITE.
- **WRITE**
  - Assert `tag_wr_en_o=1`, `tag_wr_tag_o` = latched tag, and set `valid[idx] <= 1`.
  - Assert `resp_valid_o=1` with `resp_hit_o=0`, then go to IDLE.
- **FLUSH**
  - Each cycle: `tag_index_o = fcnt`, `tag_wr_en_o=1`, `tag_wr_tag_o=0`, `valid[fcnt] <= 0`, then increment `fcnt`.
  - When `fcnt == 2^CACHE_INDEX_AW-1`, clear `flush_pend` and go to IDLE.
- A `flush_i` pulse outside IDLE sets `flush_pend`. It is serviced on the next IDLE cycle, and requests are blocked until then.
- A `flush_i` pulse during FLUSH is absorbed and does not restart the sweep.
- `tag_wr_en_o = 0` in every state other than WRITE and FLUSH.
- `refill_ack_i` outside MISS is ignored.

## Timing
- **Reset values:**
  - State IDLE; all valid bits 0.
  - `flush_pend=0`, `fcnt=0`, counters 0.
  - `req_ready_o=1`, `busy_o=0`.
  - `resp_valid_o`, `resp_hit_o`, `refill_req_o` and `tag_wr_en_o` all 0.
  - `refill_addr_o`, `tag_index_o` and `tag_wr_tag_o` all 0.
- Tag RAM contents are not cleared by reset; the cleared valid bits gate them.
- **Hit latency:** accepted at cycle N, response at N+1, ready again at N+2.
- **Miss latency:** accepted at N, LOOKUP at N+1, `refill_req_o` from N+2. With ack sampled at cycle A, WRITE and the response occur at A+1, and the controller is ready at A+2.
- A request to the same index immediately after a miss hits, because the RAM write in WRITE lands before the next LOOKUP read.
- A flush takes exactly 2^`CACHE_INDEX_AW` cycles in FLUSH: 256 by default.
- Reset asserted mid-refill drops `refill_req_o` asynchronously. No response is produced for the aborted request.

## Configuration
- **`CACHE_PERF_CNT_EN` defined:**
  - `hit_cnt_o` increments on each `resp_valid_o & resp_hit_o`.
  - `miss_cnt_o` increments on each `resp_valid_o & ~resp_hit_o`.
  - Both are 32-bit, saturate at 0xFFFF_FFFF, and are cleared by reset and by entry into FLUSH.
- **Undefined:** no counter registers are built; both ports are tied to 0.

## Test plan
- **Cold miss:** reset, request 0x0000_1230 → MISS with `refill_addr_o=0x0000_1230`. Ack after 5 cycles → WRITE with index 0x23 and tag 0x00001, then `resp_valid_o=1`, `resp_hit_o=0`.
- **Hit:** repeat 0x0000_1234 → response at N+1 with `resp_hit_o=1`, no `refill_req_o`.
- **Conflict:** request 0x0000_2230 (same index 0x23, tag 0x00002) → miss. Then 0x0000_1230 → miss again.
- **Flush:**
  - `flush_i` while in MISS → `flush_pend` set.
  - After the ack, the response arrives, then exactly 256 FLUSH cycles with `tag_wr_en_o=1`.
  - The next request to 0x0000_1230 misses.
- **Simultaneous events:** `flush_i` and `req_valid_i` in the same IDLE cycle → `req_ready_o=0` and FLUSH is entered.
- **Reset abort:** assert `rst` during MISS → `refill_req_o` drops in the same cycle, all valid bits are clear, and a later request misses.
- **`CACHE_PERF_CNT_EN` defined:** 1 miss + 3 hits → `hit_cnt_o=3`, `miss_cnt_o=1`.
